// File: rtl/axi_burst_sram_slave.sv
// AXI4 INCR-burst slave backed by a word-addressed SRAM; one transaction at a time.
// Optional macro SRAM_RANGE_CHECK_EN: addresses beyond the array return DECERR instead of aliasing.
module axi_burst_sram_slave #(
  parameter int ID_W      = 8,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 1024
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ID_W-1:0]     AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [3:0]          AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ID_W-1:0]     ARID,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [3:0]          ARLEN,
  input  logic [2:0]          ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [ID_W-1:0]     RID,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY
);

  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WDATA = 2'd1;
  localparam logic [1:0] S_WRESP = 2'd2;
  localparam logic [1:0] S_RDATA = 2'd3;

  logic [1:0]       state;
  logic [ID_W-1:0]  id_q;
  logic [IDX_W-1:0] addr_q;
  logic [3:0]       len_q;
  logic [3:0]       cnt_q;
  logic             err_q;
  logic             oor_q;
  logic             prio_read;
  logic [DATA_W-1:0] mem [MEM_WORDS];

  logic grant_w, grant_r, aw_hs, ar_hs, w_hs, r_hs, last_beat;
  logic aw_bad, ar_bad, aw_oor, ar_oor;
  logic [1:0] resp;
  logic unused_addr_bits;

`ifdef SRAM_RANGE_CHECK_EN
  assign aw_oor = |AWADDR[ADDR_W-1:IDX_W+2];
  assign ar_oor = |ARADDR[ADDR_W-1:IDX_W+2];
  assign unused_addr_bits = ^{AWADDR[1:0], ARADDR[1:0]};
`else
  assign aw_oor = 1'b0;
  assign ar_oor = 1'b0;
  assign unused_addr_bits = ^{AWADDR[ADDR_W-1:IDX_W+2], AWADDR[1:0],
                              ARADDR[ADDR_W-1:IDX_W+2], ARADDR[1:0]};
`endif

  // With both requests pending, prio_read picks the winner; a lone request always wins.
  assign grant_r = ARVALID & (~AWVALID | prio_read);
  assign grant_w = AWVALID & (~ARVALID | ~prio_read);

  assign AWREADY = (state == S_IDLE) & grant_w;
  assign ARREADY = (state == S_IDLE) & grant_r;
  assign WREADY  = (state == S_WDATA);
  assign BVALID  = (state == S_WRESP);
  assign RVALID  = (state == S_RDATA);

  assign aw_hs     = AWVALID & AWREADY;
  assign ar_hs     = ARVALID & ARREADY;
  assign w_hs      = WVALID & WREADY;
  assign r_hs      = RVALID & RREADY;
  assign last_beat = (cnt_q == len_q);
  assign aw_bad    = (AWSIZE != 3'b010) | (AWBURST != 2'b01);
  assign ar_bad    = (ARSIZE != 3'b010) | (ARBURST != 2'b01);
  assign resp      = oor_q ? 2'b11 : (err_q ? 2'b10 : 2'b00);

  assign BID   = BVALID ? id_q : '0;
  assign BRESP = BVALID ? resp : 2'b00;
  assign RID   = RVALID ? id_q : '0;
  assign RRESP = RVALID ? resp : 2'b00;
  assign RLAST = RVALID & last_beat;
  assign RDATA = (RVALID && !oor_q) ? mem[addr_q] : '0;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= S_IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      oor_q     <= 1'b0;
      prio_read <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (aw_hs) begin
            id_q      <= AWID;
            addr_q    <= AWADDR[2 +: IDX_W];
            len_q     <= AWLEN;
            cnt_q     <= '0;
            err_q     <= aw_bad;
            oor_q     <= aw_oor;
            prio_read <= ~prio_read;
            state     <= S_WDATA;
          end else if (ar_hs) begin
            id_q      <= ARID;
            addr_q    <= ARADDR[2 +: IDX_W];
            len_q     <= ARLEN;
            cnt_q     <= '0;
            err_q     <= ar_bad;
            oor_q     <= ar_oor;
            prio_read <= ~prio_read;
            state     <= S_RDATA;
          end
        end
        // Only the beat count ends a write burst; WLAST is merely checked against it.
        S_WDATA: begin
          if (w_hs) begin
            addr_q <= addr_q + IDX_W'(1);
            cnt_q  <= cnt_q + 4'd1;
            if (WLAST != last_beat) err_q <= 1'b1;
            if (last_beat) state <= S_WRESP;
          end
        end
        S_WRESP: begin
          if (BREADY) state <= S_IDLE;
        end
        S_RDATA: begin
          if (r_hs) begin
            addr_q <= addr_q + IDX_W'(1);
            cnt_q  <= cnt_q + 4'd1;
            if (last_beat) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Array has no reset, so contents survive ARESET, including beats of an abandoned burst.
  always_ff @(posedge ACLK) begin
    if (w_hs && !oor_q) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (WSTRB[b]) mem[addr_q][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_sram_slave.sv
// Randomised self-checking bench for axi_burst_sram_slave against a transaction-level memory model.
// Honours SRAM_RANGE_CHECK_EN the same way the design does.
module tb_axi_burst_sram_slave;

  localparam int MEM_WORDS = 1024;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [7:0]  AWID, ARID, BID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [3:0]  AWLEN, ARLEN, WSTRB;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

  int errors = 0;
  int checks = 0;

  logic [31:0] model_mem [MEM_WORDS];
  logic [31:0] wdata_v [16];
  logic [3:0]  wstrb_v [16];
  logic [15:0] wlast_v;
  logic [31:0] rready_pat;

  axi_burst_sram_slave #(.ID_W(8), .ADDR_W(32), .DATA_W(32), .MEM_WORDS(MEM_WORDS)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic bit model_oor(input logic [31:0] a);
`ifdef SRAM_RANGE_CHECK_EN
    return a >= 32'(MEM_WORDS * 4);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int model_word(input logic [31:0] a, input int beat);
    return ((int'(a >> 2) % MEM_WORDS) + beat) % MEM_WORDS;
  endfunction

  task automatic applyReset();
    ARESET = 1'b1;
    AWVALID = 0; WVALID = 0; BREADY = 0; ARVALID = 0; RREADY = 0;
    AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 3'b010; AWBURST = 2'b01;
    ARID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 3'b010; ARBURST = 2'b01;
    WDATA = 0; WSTRB = 0; WLAST = 0;
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
  endtask

  task automatic write_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
    int n;
    bit err, oor;
    int w;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    n = 0;
    @(negedge ACLK);
    while (!AWREADY && n < 20) begin @(negedge ACLK); n++; end
    checkOutput("awready", AWREADY, 1);
    @(posedge ACLK); #1 AWVALID = 1'b0;
    oor = model_oor(addr);
    err = (size != 3'b010) || (burst != 2'b01);
    for (int i = 0; i <= int'(len); i++) begin
      WVALID = 1'b1; WDATA = wdata_v[i]; WSTRB = wstrb_v[i]; WLAST = wlast_v[i];
      @(negedge ACLK);
      checkOutput("wready", WREADY, 1);
      if (wlast_v[i] != (i == int'(len))) err = 1'b1;
      w = model_word(addr, i);
      if (!oor)
        for (int b = 0; b < 4; b++)
          if (wstrb_v[i][b]) model_mem[w][8*b +: 8] = wdata_v[i][8*b +: 8];
      @(posedge ACLK); #1;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    @(negedge ACLK);
    checkOutput("bvalid", BVALID, 1);
    checkOutput("bid", BID, id);
    checkOutput("bresp", BRESP, oor ? 2'b11 : (err ? 2'b10 : 2'b00));
    BREADY = 1'b1;
    @(posedge ACLK); #1 BREADY = 1'b0;
    @(negedge ACLK);
    checkOutput("bvalid_drop", BVALID, 0);
    @(posedge ACLK); #1;
  endtask

  task automatic read_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
    int n, acc, cyc;
    bit err, oor;
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    n = 0;
    @(negedge ACLK);
    while (!ARREADY && n < 20) begin @(negedge ACLK); n++; end
    checkOutput("arready", ARREADY, 1);
    @(posedge ACLK); #1 ARVALID = 1'b0;
    oor = model_oor(addr);
    err = (size != 3'b010) || (burst != 2'b01);
    acc = 0; cyc = 0;
    RREADY = rready_pat[0];
    while (acc <= int'(len) && cyc < 100) begin
      @(negedge ACLK);
      checkOutput("rvalid", RVALID, 1);
      checkOutput("rdata", RDATA, oor ? 32'h0 : model_mem[model_word(addr, acc)]);
      checkOutput("rlast", RLAST, acc == int'(len));
      checkOutput("rresp", RRESP, oor ? 2'b11 : (err ? 2'b10 : 2'b00));
      checkOutput("rid", RID, id);
      if (RVALID && RREADY) acc++;
      @(posedge ACLK); #1;
      cyc++;
      RREADY = (cyc < 32) ? rready_pat[cyc] : 1'b1;
    end
    RREADY = 1'b0;
    checkOutput("rbeats", acc, int'(len) + 1);
    @(negedge ACLK);
    checkOutput("rvalid_drop", RVALID, 0);
    @(posedge ACLK); #1;
  endtask

  task automatic set_good_beats(input logic [3:0] len);
    for (int i = 0; i < 16; i++) begin
      wdata_v[i] = $urandom;
      wstrb_v[i] = 4'hF;
    end
    wlast_v = 16'h0;
    wlast_v[len] = 1'b1;
  endtask

  initial begin
    applyReset();
    ARESET = 1'b1;
    @(negedge ACLK);
    checkOutput("rst_awready", AWREADY, 0);
    checkOutput("rst_wready", WREADY, 0);
    checkOutput("rst_bvalid", BVALID, 0);
    checkOutput("rst_rvalid", RVALID, 0);
    checkOutput("rst_bid_bresp", {BID, BRESP}, 0);
    checkOutput("rst_r_outs", {RID, RDATA, RRESP, RLAST}, 0);
    @(posedge ACLK); #1 ARESET = 1'b0;

    // Fill the whole array so every later read has a known value.
    for (int k = 0; k < MEM_WORDS / 16; k++) begin
      set_good_beats(4'd15);
      write_burst(8'(k), 32'(k * 64), 4'd15, 3'b010, 2'b01);
    end

    set_good_beats(4'd3);
    for (int i = 0; i < 4; i++) wdata_v[i] = 32'(i + 1);
    write_burst(8'h5C, 32'h40, 4'd3, 3'b010, 2'b01);
    rready_pat = 32'hFFFF_FFFF;
    read_burst(8'h3A, 32'h40, 4'd3, 3'b010, 2'b01);
    rready_pat = {25'h1FF_FFFF, 7'b1011001};
    read_burst(8'h3B, 32'h40, 4'd3, 3'b010, 2'b01);

    set_good_beats(4'd1);
    wdata_v[0] = 32'hAAAA_BBBB; wdata_v[1] = 32'hAAAA_BBBB;
    wstrb_v[0] = 4'b0011; wstrb_v[1] = 4'b0011;
    write_burst(8'h01, 32'((MEM_WORDS - 1) * 4), 4'd1, 3'b010, 2'b01);
    rready_pat = 32'hFFFF_FFFF;
    read_burst(8'h02, 32'((MEM_WORDS - 1) * 4), 4'd1, 3'b010, 2'b01);

    set_good_beats(4'd1);
    wlast_v = 16'b01;
    write_burst(8'h77, 32'h100, 4'd1, 3'b010, 2'b01);
    set_good_beats(4'd2);
    write_burst(8'h78, 32'h200, 4'd2, 3'b011, 2'b01);
    read_burst(8'h79, 32'h100, 4'd1, 3'b010, 2'b10);

    // Simultaneous AW/AR straight after reset: read wins, write follows.
    applyReset();
    ARID = 8'h11; ARADDR = 32'h40; ARLEN = 0; ARSIZE = 3'b010; ARBURST = 2'b01; ARVALID = 1'b1;
    AWID = 8'h22; AWADDR = 32'h80; AWLEN = 0; AWSIZE = 3'b010; AWBURST = 2'b01; AWVALID = 1'b1;
    @(negedge ACLK);
    checkOutput("arb_ar_first", ARREADY, 1);
    checkOutput("arb_aw_held", AWREADY, 0);
    @(posedge ACLK); #1 ARVALID = 1'b0; RREADY = 1'b1;
    @(negedge ACLK);
    checkOutput("arb_rdata", RDATA, model_mem[16]);
    checkOutput("arb_aw_wait", AWREADY, 0);
    @(posedge ACLK); #1 RREADY = 1'b0;
    @(negedge ACLK);
    checkOutput("arb_aw_next", AWREADY, 1);
    @(posedge ACLK); #1 AWVALID = 1'b0;
    WVALID = 1'b1; WDATA = 32'h5A5A_0001; WSTRB = 4'hF; WLAST = 1'b1;
    @(negedge ACLK);
    checkOutput("arb_wready", WREADY, 1);
    model_mem[32] = 32'h5A5A_0001;
    @(posedge ACLK); #1 WVALID = 1'b0; WLAST = 1'b0;
    @(negedge ACLK);
    checkOutput("arb_bvalid", BVALID, 1);
    checkOutput("arb_bid", BID, 8'h22);
    BREADY = 1'b1;
    @(posedge ACLK); #1 BREADY = 1'b0;
    read_burst(8'h23, 32'h80, 4'd0, 3'b010, 2'b01);

    // Above-array address: DECERR with the range check, aliasing to word 0 without it.
    read_burst(8'h40, 32'h1000, 4'd0, 3'b010, 2'b01);
    set_good_beats(4'd0);
    write_burst(8'h41, 32'h1000, 4'd0, 3'b010, 2'b01);
    read_burst(8'h42, 32'h0, 4'd0, 3'b010, 2'b01);

    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      logic [3:0]  len;
      logic [2:0]  sz;
      a   = {$urandom_range(0, MEM_WORDS - 1), 2'b00};
      if ($urandom_range(0, 7) == 0) a = a | (32'h1000 << $urandom_range(0, 19));
      len = 4'($urandom_range(0, 15));
      sz  = ($urandom_range(0, 9) == 0) ? 3'b001 : 3'b010;
      rready_pat = $urandom | $urandom;
      if ($urandom_range(0, 1) == 1) begin
        set_good_beats(len);
        for (int i = 0; i < 16; i++) wstrb_v[i] = 4'($urandom);
        if ($urandom_range(0, 5) == 0) wlast_v = 16'($urandom);
        write_burst(8'($urandom), a, len, sz, 2'b01);
      end else begin
        read_burst(8'($urandom), a, len, sz, 2'b01);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
